ps2_keymap_rx: RTL and testbench

//   Parametrised PS/2 keyboard receiver with a configurable key map. Samples ps2_clk/ps2_data in the clk domain.

---
 rtl/ps2_keymap_rx_if.sv | 19 +
 rtl/ps2_keymap_rx.sv | 162 ++++++++++++++++
 tb/tb_ps2_keymap_rx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keymap_rx_if.sv
// Key/scan-code result bus from the PS/2 keymap receiver to the game core.
interface ps2_keymap_rx_if #(
    parameter int unsigned NUM_KEYS = 8
);
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                scan_valid;
    logic [7:0]          scan_code;
    logic                frame_err;

    modport master (
        output key_state, key_press, key_release, scan_valid, scan_code, frame_err
    );

    modport slave (
        input key_state, key_press, key_release, scan_valid, scan_code, frame_err
    );
endinterface

// File: rtl/ps2_keymap_rx.sv
// PS/2 keyboard receiver: frame validation, E0/F0 prefix decode, per-key held state and pulses.
// Optional macro PS2_TYPEMATIC_SUPPRESS_EN: key_press only fires on a key's first make.
module ps2_keymap_rx #(
    parameter int unsigned               NUM_KEYS    = 8,
    parameter logic [9*NUM_KEYS-1:0]     KEYMAP      = {9'h174, 9'h172, 9'h16B, 9'h175,
                                                        9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter int unsigned               FILTER_LEN  = 8,
    parameter int unsigned               TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    ps2_keymap_rx_if.master  kb
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic [1:0]          clk_sync;
    logic [1:0]          data_sync;
    logic                clk_filt;
    logic [FW-1:0]       flt_cnt;
    logic                fall;
    logic                bit_in;
    state_t              state;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic                par_err;
    logic [TW-1:0]       tcnt;
    logic                ext;
    logic                brk;
    logic [NUM_KEYS-1:0] hit_c;

    // Synchroniser, glitch filter on ps2_clk, and registered fall strobe with its data sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            flt_cnt   <= '0;
            fall      <= 1'b0;
            bit_in    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            fall      <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
                fall     <= clk_filt;
                bit_in   <= data_sync[1];
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    // Keys whose map entry equals the byte being completed under the current ext flag
    always_comb begin
        hit_c = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            hit_c[i] = (KEYMAP[9*i +: 9] == {ext, shreg});
        end
    end

    // Frame FSM, timeout, prefix flags and key map update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shreg          <= '0;
            par_err        <= 1'b0;
            tcnt           <= '0;
            ext            <= 1'b0;
            brk            <= 1'b0;
            kb.key_state   <= '0;
            kb.key_press   <= '0;
            kb.key_release <= '0;
            kb.scan_valid  <= 1'b0;
            kb.scan_code   <= '0;
            kb.frame_err   <= 1'b0;
        end else begin
            kb.key_press   <= '0;
            kb.key_release <= '0;
            kb.scan_valid  <= 1'b0;
            kb.frame_err   <= 1'b0;

            if (fall) begin
                tcnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (!bit_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            par_err <= 1'b0;
                        end
                    end
                    DATA: begin
                        shreg <= {bit_in, shreg[7:1]};
                        if (bit_cnt == 3'd7) state <= PARITY;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: begin
                        par_err <= ~(^{shreg, bit_in});
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (par_err || !bit_in) begin
                            kb.frame_err <= 1'b1;
                            ext          <= 1'b0;
                            brk          <= 1'b0;
                        end else begin
                            kb.scan_valid <= 1'b1;
                            kb.scan_code  <= shreg;
                            if (shreg == 8'hE0) begin
                                ext <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                brk <= 1'b1;
                            end else begin
                                ext <= 1'b0;
                                brk <= 1'b0;
                                if (brk) begin
                                    kb.key_state   <= kb.key_state & ~hit_c;
                                    kb.key_release <= kb.key_state & hit_c;
                                end else begin
                                    kb.key_state <= kb.key_state | hit_c;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
                                    kb.key_press <= hit_c & ~kb.key_state;
`else
                                    kb.key_press <= hit_c;
`endif
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // Silence mid-frame: abandon the frame and any pending prefix
                if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    state        <= IDLE;
                    tcnt         <= '0;
                    ext          <= 1'b0;
                    brk          <= 1'b0;
                    kb.frame_err <= 1'b1;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keymap_rx.sv
// Randomised bench for ps2_keymap_rx against a frame-level behavioural model.
module tb_ps2_keymap_rx;
    localparam int unsigned NUM_KEYS    = 8;
    localparam int unsigned FILTER_LEN  = 8;
    localparam int unsigned TIMEOUT_CYC = 300;
    localparam int          HALF        = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_keymap_rx_if #(.NUM_KEYS(NUM_KEYS)) kb ();

    ps2_keymap_rx #(
        .NUM_KEYS(NUM_KEYS),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .kb(kb)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Map table as {ext, code}, index = key number
    logic [8:0] km [NUM_KEYS] = '{9'h01D, 9'h01C, 9'h01B, 9'h023,
                                   9'h175, 9'h16B, 9'h172, 9'h174};

    logic [7:0] m_state;
    logic [7:0] m_code;
    bit         m_ext, m_brk;
    int         exp_valid, exp_err;
    int         exp_press [NUM_KEYS];
    int         exp_rel   [NUM_KEYS];

    int         obs_valid, obs_err, overlap, wide;
    int         obs_press [NUM_KEYS];
    int         obs_rel   [NUM_KEYS];
    logic       pv, pe;
    logic [7:0] pp, pr;

    initial begin
        obs_valid = 0; obs_err = 0; overlap = 0; wide = 0;
        pv = 0; pe = 0; pp = '0; pr = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            obs_press[i] = 0; obs_rel[i] = 0; exp_press[i] = 0; exp_rel[i] = 0;
        end
    end

    // Pulse monitor: counts events and flags overlaps / pulses wider than one cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (kb.scan_valid) obs_valid++;
            if (kb.frame_err)  obs_err++;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (kb.key_press[i])   obs_press[i]++;
                if (kb.key_release[i]) obs_rel[i]++;
            end
            if ((kb.key_press & kb.key_release) != '0) overlap++;
            if ((kb.scan_valid && pv) || (kb.frame_err && pe) ||
                ((kb.key_press & pp) != '0) || ((kb.key_release & pr) != '0)) wide++;
        end
        pv = kb.scan_valid; pe = kb.frame_err; pp = kb.key_press; pr = kb.key_release;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            ps2_data = bits[k];
            wait_clk(HALF);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic model_reset();
        m_state = '0; m_code = '0; m_ext = 0; m_brk = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit err);
        if (err) begin
            exp_err++;
            m_ext = 0; m_brk = 0;
        end else begin
            exp_valid++;
            m_code = b;
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (km[i] == {m_ext, b}) begin
                        if (m_brk) begin
                            if (m_state[i]) exp_rel[i]++;
                            m_state[i] = 1'b0;
                        end else begin
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
                            if (!m_state[i]) exp_press[i]++;
`else
                            exp_press[i]++;
`endif
                            m_state[i] = 1'b1;
                        end
                    end
                end
                m_ext = 0; m_brk = 0;
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid_cnt"}, obs_valid, exp_valid);
        check({tag, ".err_cnt"},   obs_err,   exp_err);
        check({tag, ".scan_code"}, 32'(kb.scan_code), 32'(m_code));
        check({tag, ".key_state"}, 32'(kb.key_state), 32'(m_state));
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b,
                              input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        wait_clk(40);
        model_frame(b, bad_par | bad_stop);
        check_state(tag);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".key_state"},   32'(kb.key_state),   0);
        check({tag, ".key_press"},   32'(kb.key_press),   0);
        check({tag, ".key_release"}, 32'(kb.key_release), 0);
        check({tag, ".scan_valid"},  32'(kb.scan_valid),  0);
        check({tag, ".scan_code"},   32'(kb.scan_code),   0);
        check({tag, ".frame_err"},   32'(kb.frame_err),   0);
    endtask

    logic [7:0] pool [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};

    initial begin
        model_reset();
        exp_valid = 0; exp_err = 0;
        wait_clk(5);
        #1 check_outputs_zero("reset");
        rst_n = 1'b1;
        wait_clk(20);

        send_frame("make_w", 8'h1D, 0, 0);
        check("make_w.press0", obs_press[0], 1);
        send_frame("brk_pfx", 8'hF0, 0, 0);
        send_frame("brk_w", 8'h1D, 0, 0);
        check("brk_w.rel0", obs_rel[0], 1);

        send_frame("ext_pfx", 8'hE0, 0, 0);
        send_frame("make_up", 8'h75, 0, 0);
        send_frame("plain_75", 8'h75, 0, 0);
        send_frame("ext_pfx2", 8'hE0, 0, 0);
        send_frame("brk_pfx2", 8'hF0, 0, 0);
        send_frame("brk_up", 8'h75, 0, 0);
        check("brk_up.rel4", obs_rel[4], 1);

        send_frame("bad_par", 8'h1C, 1, 0);
        send_frame("good_a", 8'h1C, 0, 0);
        send_frame("bad_stop", 8'h1B, 0, 1);

        // Break prefix then a truncated frame left to time out
        send_frame("to_pfx", 8'hF0, 0, 0);
        send_bits(11'h7C0, 6);
        wait_clk(TIMEOUT_CYC + 100);
        model_frame(8'h00, 1);
        check_state("timeout");
        send_frame("make_d", 8'h23, 0, 0);

        // Lone falling edge with data high while idle is ignored
        send_bits(11'h7FF, 1);
        wait_clk(TIMEOUT_CYC + 50);
        check_state("idle_fall");

        for (int k = 0; k < 3; k++) send_frame("typematic", 8'h1D, 0, 0);
        check("typematic.press0", obs_press[0], exp_press[0]);

        for (int k = 0; k < 40; k++) begin
            int   sel, e;
            logic [7:0] b;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)       b = pool[$urandom_range(0, 7)];
            else if (sel == 5) b = 8'hE0;
            else if (sel == 6) b = 8'hF0;
            else               b = 8'($urandom);
            e = int'($urandom_range(0, 9));
            send_frame("rand", b, e == 0, e == 1);
        end

        for (int i = 0; i < NUM_KEYS; i++) begin
            check($sformatf("press_cnt[%0d]", i), obs_press[i], exp_press[i]);
            check($sformatf("rel_cnt[%0d]", i),   obs_rel[i],   exp_rel[i]);
        end
        check("overlap", overlap, 0);
        check("pulse_width", wide, 0);

        // Reset in the middle of a frame while a key is held
        send_frame("pre_rst", 8'h1D, 0, 0);
        check("pre_rst.held", 32'(kb.key_state[0]), 1);
        send_bits(11'h7F0, 4);
        rst_n = 1'b0;
        #1 check_outputs_zero("mid_rst");
        wait_clk(5);
        rst_n = 1'b1;
        model_reset();
        wait_clk(20);
        send_frame("post_rst", 8'h1C, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
